// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-side signal bundle for hazard_stall_ctrl: hazard inputs, stage controls, forwarding selects.
interface hazard_stall_ctrl_if;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rt;
  logic       ex_memread;
  logic [4:0] ex_rd;
  logic [4:0] ex_rs;
  logic [4:0] ex_rt;
  logic       branch_taken;
  logic       mem_req;
  logic       mem_ready;
  logic       mem_regwrite;
  logic [4:0] mem_rd;
  logic       wb_regwrite;
  logic [4:0] wb_rd;
  logic       pc_write;
  logic       ifid_write;
  logic       ifid_flush;
  logic       idex_bubble;
  logic       exmem_hold;
  logic       memwb_bubble;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
  logic [1:0] state_o;
  logic       mem_error;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_memread, ex_rd, ex_rs, ex_rt, branch_taken,
           mem_req, mem_ready, mem_regwrite, mem_rd, wb_regwrite, wb_rd,
    input  pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold, memwb_bubble,
           fwd_a, fwd_b, state_o, mem_error
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_memread, ex_rd, ex_rs, ex_rt, branch_taken,
           mem_req, mem_ready, mem_regwrite, mem_rd, wb_regwrite, wb_rd,
    output pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold, memwb_bubble,
           fwd_a, fwd_b, state_o, mem_error
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// 5-stage pipeline sequencing: stall/flush/bubble control, EX forwarding, memory-wait watchdog.
// Optional stall counter output enabled by defining HAZARD_STALL_COUNTER_EN.
module hazard_stall_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT  = 255,
  parameter int unsigned CNT_W        = 16
) (
  input  logic               clock,
  input  logic               reset,
  hazard_stall_ctrl_if.slave bus
`ifdef HAZARD_STALL_COUNTER_EN
  ,
  output logic [CNT_W-1:0]   stall_count
`endif
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT  > 1) ? $clog2(MEM_TIMEOUT + 1)  : 1;
  localparam int unsigned FL_W   = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  state_t            r_state;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [FL_W-1:0]   r_flush_cnt;
  logic              r_mem_error;

  logic              w_load_use;
  logic              w_mem_stall;
  logic              w_stall_out;
  logic [WAIT_W-1:0] w_wait_inc;
  logic              w_pc_write;
  logic              w_ifid_write;
  logic              w_ifid_flush;
  logic              w_idex_bubble;
  logic              w_exmem_hold;
  logic              w_memwb_bubble;
  logic [1:0]        w_fwd_a;
  logic [1:0]        w_fwd_b;

  assign w_load_use  = bus.ex_memread && (bus.ex_rd != '0) &&
                       ((bus.ex_rd == bus.id_rs) || (bus.id_uses_rt && (bus.ex_rd == bus.id_rt)));
  assign w_mem_stall = bus.mem_req && !bus.mem_ready;
  // In MEM_WAIT the stall is released only by mem_ready; elsewhere the raw stall term applies.
  assign w_stall_out = (r_state == MEM_WAIT) ? !bus.mem_ready : w_mem_stall;
  assign w_wait_inc  = r_wait_cnt + WAIT_W'(1);

  always_comb begin
    w_pc_write     = 1'b1;
    w_ifid_write   = 1'b1;
    w_ifid_flush   = 1'b0;
    w_idex_bubble  = 1'b0;
    w_exmem_hold   = 1'b0;
    w_memwb_bubble = 1'b0;
    if (w_stall_out) begin
      w_pc_write     = 1'b0;
      w_ifid_write   = 1'b0;
      w_exmem_hold   = 1'b1;
      w_memwb_bubble = 1'b1;
    end else if ((r_state == FLUSH) || bus.branch_taken) begin
      w_ifid_flush   = 1'b1;
      w_idex_bubble  = 1'b1;
    end else if (w_load_use) begin
      w_pc_write     = 1'b0;
      w_ifid_write   = 1'b0;
      w_idex_bubble  = 1'b1;
    end
    if (reset) begin
      w_pc_write     = 1'b0;
      w_ifid_write   = 1'b0;
      w_ifid_flush   = 1'b1;
      w_idex_bubble  = 1'b1;
      w_exmem_hold   = 1'b0;
      w_memwb_bubble = 1'b1;
    end
  end

  // EX/MEM result wins over MEM/WB; r0 is never forwarded.
  always_comb begin
    w_fwd_a = 2'b00;
    w_fwd_b = 2'b00;
    if (!reset) begin
      if (bus.mem_regwrite && (bus.mem_rd != '0) && (bus.mem_rd == bus.ex_rs))
        w_fwd_a = 2'b10;
      else if (bus.wb_regwrite && (bus.wb_rd != '0) && (bus.wb_rd == bus.ex_rs))
        w_fwd_a = 2'b01;
      if (bus.mem_regwrite && (bus.mem_rd != '0) && (bus.mem_rd == bus.ex_rt))
        w_fwd_b = 2'b10;
      else if (bus.wb_regwrite && (bus.wb_rd != '0) && (bus.wb_rd == bus.ex_rt))
        w_fwd_b = 2'b01;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= RUN;
      r_wait_cnt  <= '0;
      r_flush_cnt <= '0;
      r_mem_error <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_mem_stall) begin
            r_state    <= MEM_WAIT;
            r_wait_cnt <= WAIT_W'(1);
            if (MEM_TIMEOUT <= 1) r_mem_error <= 1'b1;
          end else if (bus.branch_taken && (FLUSH_CYCLES > 1)) begin
            r_state     <= FLUSH;
            r_flush_cnt <= FL_W'(FLUSH_CYCLES - 1);
          end
        end
        MEM_WAIT: begin
          if (bus.mem_ready) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
          end else if (r_wait_cnt != WAIT_W'(MEM_TIMEOUT)) begin
            r_wait_cnt <= w_wait_inc;
            if (w_wait_inc == WAIT_W'(MEM_TIMEOUT)) r_mem_error <= 1'b1;
          end
        end
        FLUSH: begin
          if (w_mem_stall) begin
            r_state     <= MEM_WAIT;
            r_wait_cnt  <= WAIT_W'(1);
            r_flush_cnt <= '0;
            if (MEM_TIMEOUT <= 1) r_mem_error <= 1'b1;
          end else if (r_flush_cnt <= FL_W'(1)) begin
            r_state     <= RUN;
            r_flush_cnt <= '0;
          end else begin
            r_flush_cnt <= r_flush_cnt - FL_W'(1);
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

`ifdef HAZARD_STALL_COUNTER_EN
  logic [CNT_W-1:0] r_stall_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_stall_count <= '0;
    end else if (!w_pc_write && (r_stall_count != '1)) begin
      r_stall_count <= r_stall_count + CNT_W'(1);
    end
  end

  assign stall_count = r_stall_count;
`endif

  assign bus.pc_write     = w_pc_write;
  assign bus.ifid_write   = w_ifid_write;
  assign bus.ifid_flush   = w_ifid_flush;
  assign bus.idex_bubble  = w_idex_bubble;
  assign bus.exmem_hold   = w_exmem_hold;
  assign bus.memwb_bubble = w_memwb_bubble;
  assign bus.fwd_a        = w_fwd_a;
  assign bus.fwd_b        = w_fwd_b;
  assign bus.state_o      = r_state;
  assign bus.mem_error    = r_mem_error;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl (FLUSH_CYCLES=2, MEM_TIMEOUT=8).
module tb_hazard_stall_ctrl;
  logic clock;
  logic reset;
  int   total;
  int   bad;

  hazard_stall_ctrl_if bus();

`ifdef HAZARD_STALL_COUNTER_EN
  logic [15:0] stall_count;
`endif

  hazard_stall_ctrl #(
    .FLUSH_CYCLES(2),
    .MEM_TIMEOUT (8),
    .CNT_W       (16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
`ifdef HAZARD_STALL_COUNTER_EN
    ,
    .stall_count(stall_count)
`endif
  );

  // {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold, memwb_bubble}
  logic [5:0] ctl;
  assign ctl = {bus.pc_write, bus.ifid_write, bus.ifid_flush,
                bus.idex_bubble, bus.exmem_hold, bus.memwb_bubble};

  localparam logic [5:0] C_RESET = 6'b001101;
  localparam logic [5:0] C_RUN   = 6'b110000;
  localparam logic [5:0] C_LU    = 6'b000100;
  localparam logic [5:0] C_STALL = 6'b000011;
  localparam logic [5:0] C_FLUSH = 6'b111100;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic idle();
    bus.id_rs = 5'd0; bus.id_rt = 5'd0; bus.id_uses_rt = 1'b0;
    bus.ex_memread = 1'b0; bus.ex_rd = 5'd0; bus.ex_rs = 5'd0; bus.ex_rt = 5'd0;
    bus.branch_taken = 1'b0; bus.mem_req = 1'b0; bus.mem_ready = 1'b0;
    bus.mem_regwrite = 1'b0; bus.mem_rd = 5'd0; bus.wb_regwrite = 1'b0; bus.wb_rd = 5'd0;
  endtask

  task automatic edge1();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    bus.mem_regwrite = 1'b1; bus.mem_rd = 5'd3; bus.ex_rs = 5'd3; bus.ex_rt = 5'd3;
    #1;
    total++; if (ctl !== C_RESET) begin $display("FAIL reset_ctl got=%b exp=%b", ctl, C_RESET); bad++; end
    total++; if ({bus.fwd_a, bus.fwd_b} !== 4'b0000) begin $display("FAIL reset_fwd got=%b exp=0000", {bus.fwd_a, bus.fwd_b}); bad++; end
    total++; if (bus.state_o !== 2'd0 || bus.mem_error !== 1'b0) begin $display("FAIL reset_state got=%0d/%0d exp=0/0", bus.state_o, bus.mem_error); bad++; end
    @(negedge clock);
    reset = 1'b0;
    idle();
    #1;
    total++; if (ctl !== C_RUN) begin $display("FAIL run_idle got=%b exp=%b", ctl, C_RUN); bad++; end
  endtask

  task automatic test_forward();
    idle();
    bus.mem_regwrite = 1'b1; bus.mem_rd = 5'd3; bus.wb_regwrite = 1'b1; bus.wb_rd = 5'd3;
    bus.ex_rs = 5'd3; bus.ex_rt = 5'd3;
    #1;
    total++; if ({bus.fwd_a, bus.fwd_b} !== 4'b1010) begin $display("FAIL fwd_both_mem got=%b exp=1010", {bus.fwd_a, bus.fwd_b}); bad++; end
    bus.mem_rd = 5'd0;
    #1;
    total++; if ({bus.fwd_a, bus.fwd_b} !== 4'b0101) begin $display("FAIL fwd_both_wb got=%b exp=0101", {bus.fwd_a, bus.fwd_b}); bad++; end
    bus.wb_rd = 5'd0;
    #1;
    total++; if ({bus.fwd_a, bus.fwd_b} !== 4'b0000) begin $display("FAIL fwd_none got=%b exp=0000", {bus.fwd_a, bus.fwd_b}); bad++; end
    bus.mem_rd = 5'd3; bus.wb_rd = 5'd4; bus.ex_rt = 5'd4;
    #1;
    total++; if ({bus.fwd_a, bus.fwd_b} !== 4'b1001) begin $display("FAIL fwd_split got=%b exp=1001", {bus.fwd_a, bus.fwd_b}); bad++; end
    bus.ex_rs = 5'd0; bus.mem_rd = 5'd0; bus.wb_rd = 5'd0; bus.ex_rt = 5'd0;
    #1;
    total++; if ({bus.fwd_a, bus.fwd_b} !== 4'b0000) begin $display("FAIL fwd_r0 got=%b exp=0000", {bus.fwd_a, bus.fwd_b}); bad++; end
    bus.mem_regwrite = 1'b0; bus.wb_regwrite = 1'b1; bus.wb_rd = 5'd7; bus.ex_rs = 5'd7; bus.mem_rd = 5'd7;
    #1;
    total++; if (bus.fwd_a !== 2'b01) begin $display("FAIL fwd_memwr_off got=%b exp=01", bus.fwd_a); bad++; end
    idle();
  endtask

  task automatic test_load_use();
    edge1();
    bus.ex_memread = 1'b1; bus.ex_rd = 5'd5; bus.id_rs = 5'd5;
    #1;
    total++; if (ctl !== C_LU) begin $display("FAIL lu_rs got=%b exp=%b", ctl, C_LU); bad++; end
    edge1();
    total++; if (bus.state_o !== 2'd0) begin $display("FAIL lu_state got=%0d exp=0", bus.state_o); bad++; end
    bus.ex_memread = 1'b0;
    #1;
    total++; if (ctl !== C_RUN) begin $display("FAIL lu_release got=%b exp=%b", ctl, C_RUN); bad++; end
    bus.ex_memread = 1'b1; bus.id_rs = 5'd1; bus.id_rt = 5'd5; bus.id_uses_rt = 1'b0;
    #1;
    total++; if (ctl !== C_RUN) begin $display("FAIL lu_rt_unused got=%b exp=%b", ctl, C_RUN); bad++; end
    bus.id_uses_rt = 1'b1;
    #1;
    total++; if (ctl !== C_LU) begin $display("FAIL lu_rt got=%b exp=%b", ctl, C_LU); bad++; end
    bus.ex_rd = 5'd0; bus.id_rs = 5'd0; bus.id_rt = 5'd0;
    #1;
    total++; if (ctl !== C_RUN) begin $display("FAIL lu_r0 got=%b exp=%b", ctl, C_RUN); bad++; end
    idle();
  endtask

  task automatic test_mem_wait();
    edge1();
    bus.mem_req = 1'b1; bus.mem_ready = 1'b1;
    #1;
    total++; if (ctl !== C_RUN) begin $display("FAIL mem_zero_wait got=%b exp=%b", ctl, C_RUN); bad++; end
    edge1();
    total++; if (bus.state_o !== 2'd0) begin $display("FAIL mem_zero_state got=%0d exp=0", bus.state_o); bad++; end
    bus.mem_ready = 1'b0;
    #1;
    total++; if (ctl !== C_STALL) begin $display("FAIL mem_stall_run got=%b exp=%b", ctl, C_STALL); bad++; end
    for (int i = 1; i <= 4; i++) begin
      edge1();
      total++; if (bus.state_o !== 2'd1 || ctl !== C_STALL) begin $display("FAIL mem_wait_%0d got=%0d/%b exp=1/%b", i, bus.state_o, ctl, C_STALL); bad++; end
    end
    bus.mem_ready = 1'b1;
    #1;
    total++; if (ctl !== C_RUN) begin $display("FAIL mem_ready_out got=%b exp=%b", ctl, C_RUN); bad++; end
    edge1();
    total++; if (bus.state_o !== 2'd0 || bus.mem_error !== 1'b0) begin $display("FAIL mem_done got=%0d/%0d exp=0/0", bus.state_o, bus.mem_error); bad++; end
    idle();
  endtask

  task automatic test_timeout();
    logic exp_err;
    edge1();
    bus.mem_req = 1'b1; bus.mem_ready = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      edge1();
      exp_err = (k >= 8);
      total++; if (bus.mem_error !== exp_err || bus.state_o !== 2'd1) begin $display("FAIL timeout_%0d got=%0d/%0d exp=%0d/1", k, bus.mem_error, bus.state_o, exp_err); bad++; end
    end
    bus.mem_ready = 1'b1;
    edge1();
    total++; if (bus.mem_error !== 1'b1 || bus.state_o !== 2'd0) begin $display("FAIL timeout_sticky got=%0d/%0d exp=1/0", bus.mem_error, bus.state_o); bad++; end
    idle();
    edge1();
    edge1();
    total++; if (bus.mem_error !== 1'b1) begin $display("FAIL timeout_hold got=%0d exp=1", bus.mem_error); bad++; end
    #2 reset = 1'b1;
    #1;
    total++; if (bus.mem_error !== 1'b0) begin $display("FAIL timeout_clear got=%0d exp=0", bus.mem_error); bad++; end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_branch_load_use();
    edge1();
    bus.branch_taken = 1'b1;
    bus.ex_memread = 1'b1; bus.ex_rd = 5'd9; bus.id_rs = 5'd9;
    #1;
    total++; if (ctl !== C_FLUSH) begin $display("FAIL br_lu_c1 got=%b exp=%b", ctl, C_FLUSH); bad++; end
    edge1();
    bus.branch_taken = 1'b0;
    #1;
    total++; if (bus.state_o !== 2'd2 || ctl !== C_FLUSH) begin $display("FAIL br_lu_c2 got=%0d/%b exp=2/%b", bus.state_o, ctl, C_FLUSH); bad++; end
    edge1();
    bus.ex_memread = 1'b0;
    #1;
    total++; if (bus.state_o !== 2'd0 || ctl !== C_RUN) begin $display("FAIL br_lu_end got=%0d/%b exp=0/%b", bus.state_o, ctl, C_RUN); bad++; end
    bus.branch_taken = 1'b1;
    edge1();
    bus.branch_taken = 1'b0; bus.mem_req = 1'b1; bus.mem_ready = 1'b0;
    #1;
    total++; if (bus.state_o !== 2'd2 || ctl !== C_STALL) begin $display("FAIL flush_memstall got=%0d/%b exp=2/%b", bus.state_o, ctl, C_STALL); bad++; end
    edge1();
    total++; if (bus.state_o !== 2'd1) begin $display("FAIL flush_to_wait got=%0d exp=1", bus.state_o); bad++; end
    bus.mem_ready = 1'b1;
    edge1();
    total++; if (bus.state_o !== 2'd0) begin $display("FAIL flush_wait_done got=%0d exp=0", bus.state_o); bad++; end
    idle();
  endtask

  task automatic test_async_reset();
    edge1();
    bus.mem_req = 1'b1; bus.mem_ready = 1'b0;
    edge1();
    edge1();
    edge1();
    total++; if (bus.state_o !== 2'd1) begin $display("FAIL ar_pre got=%0d exp=1", bus.state_o); bad++; end
    #2 reset = 1'b1;
    #1;
    total++; if (ctl !== C_RESET || bus.state_o !== 2'd0) begin $display("FAIL ar_now got=%b/%0d exp=%b/0", ctl, bus.state_o, C_RESET); bad++; end
    total++; if (dut.r_wait_cnt !== '0) begin $display("FAIL ar_waitcnt got=%0d exp=0", dut.r_wait_cnt); bad++; end
`ifdef HAZARD_STALL_COUNTER_EN
    total++; if (stall_count !== 16'd0) begin $display("FAIL ar_stallcnt got=%0d exp=0", stall_count); bad++; end
`endif
    idle();
    @(negedge clock);
    reset = 1'b0;
    edge1();
    total++; if (bus.state_o !== 2'd0 || ctl !== C_RUN) begin $display("FAIL ar_after got=%0d/%b exp=0/%b", bus.state_o, ctl, C_RUN); bad++; end
  endtask

`ifdef HAZARD_STALL_COUNTER_EN
  task automatic test_stall_count();
    bus.ex_memread = 1'b1; bus.ex_rd = 5'd5; bus.id_rs = 5'd5;
    edge1();
    total++; if (stall_count !== 16'd1) begin $display("FAIL sc_lu got=%0d exp=1", stall_count); bad++; end
    idle();
    edge1();
    total++; if (stall_count !== 16'd1) begin $display("FAIL sc_run got=%0d exp=1", stall_count); bad++; end
    bus.mem_req = 1'b1;
    edge1();
    edge1();
    total++; if (stall_count !== 16'd3) begin $display("FAIL sc_mem got=%0d exp=3", stall_count); bad++; end
    bus.mem_ready = 1'b1;
    edge1();
    idle();
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_forward();
    test_load_use();
    test_mem_wait();
    test_timeout();
    test_branch_load_use();
    test_async_reset();
`ifdef HAZARD_STALL_COUNTER_EN
    test_stall_count();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Central pipeline sequencing controller for the 5-stage MIPS core.
- Decides each cycle whether the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers load, hold or take a bubble.
- Generates operand-forwarding selects for the EX stage.
- Handles load-use hazards, taken-branch flushes and multi-cycle data-memory waits, with a watchdog on memory waits.

Parameters:
- FLUSH_CYCLES, 1: number of cycles the FLUSH state holds IF/ID flushed and ID/EX bubbled; minimum 1.
- MEM_TIMEOUT, 255: number of consecutive MEM_WAIT cycles before mem_error is set.
- CNT_W, 16: width of stall_count (optional feature only).

Ports:
- clock, in, 1: rising-edge clock.
- reset, in, 1: asynchronous, active-high reset.
- id_rs, in, 5: rs field of the instruction in ID.
- id_rt, in, 5: rt field of the instruction in ID.
- id_uses_rt, in, 1: the ID instruction reads rt.
- ex_memread, in, 1: the instruction in EX is a load.
- ex_rd, in, 5: destination register of the EX instruction.
- ex_rs, in, 5: rs source of the EX instruction.
- ex_rt, in, 5: rt source of the EX instruction.
- branch_taken, in, 1: a branch resolved taken in EX this cycle.
- mem_req, in, 1: the MEM-stage instruction accesses data memory.
- mem_ready, in, 1: data memory completes the access this cycle.
- mem_regwrite, in, 1: RegWrite bit of the EX/MEM register.
- mem_rd, in, 5: destination register in EX/MEM.
- wb_regwrite, in, 1: RegWrite bit (WBreg[1]) of the MEM/WB register.
- wb_rd, in, 5: RegRDreg of the MEM/WB register.
- pc_write, out, 1: PC load enable.
- ifid_write, out, 1: IF/ID load enable.
- ifid_flush, out, 1: IF/ID loads a NOP.
- idex_bubble, out, 1: ID/EX control fields are zeroed.
- exmem_hold, out, 1: EX/MEM holds its contents.
- memwb_bubble, out, 1: MEM/WB loads WB=0 (no writeback).
- fwd_a, out, 2: ALU operand A source.
- fwd_b, out, 2: ALU operand B source.
- state_o, out, 2: current state (RUN=0, MEM_WAIT=1, FLUSH=2).
- mem_error, out, 1: sticky memory-timeout flag.

Behaviour:
- Reset (asynchronous, applies immediately):
  - State goes to RUN; wait counter 0; flush counter 0; mem_error 0.
  - While reset is high: pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1, exmem_hold=0, memwb_bubble=1, fwd_a=fwd_b=00.
  - The first non-reset rising edge is evaluated in RUN.
- Forwarding is combinational and state-independent:
  - fwd_a=10 if mem_regwrite && mem_rd!=0 && mem_rd==ex_rs.
  - Else fwd_a=01 if wb_regwrite && wb_rd!=0 && wb_rd==ex_rs.
  - Else fwd_a=00.
  - fwd_b is computed the same way using ex_rt.
  - EX/MEM has priority over MEM/WB. Register 0 is never forwarded.
- Hazard terms:
  - load_use = ex_memread && ex_rd!=0 && (ex_rd==id_rs || (id_uses_rt && ex_rd==id_rt)).
  - mem_stall = mem_req && !mem_ready.
- Priority within a cycle: mem_stall > branch_taken > load_use.
- RUN state:
  - mem_stall:
    - pc_write=0, ifid_write=0, idex_bubble=0 (ID/EX holds because ifid_write=0 and the ID/EX enable is tied to ifid_write), exmem_hold=1, memwb_bubble=1.
    - Next state MEM_WAIT; wait counter=1.
  - Else branch_taken:
    - pc_write=1, ifid_flush=1, idex_bubble=1.
    - If FLUSH_CYCLES>1: next state FLUSH with flush counter=FLUSH_CYCLES-1. Otherwise stay in RUN.
  - Else load_use:
    - pc_write=0, ifid_write=0, idex_bubble=1 for exactly this cycle; stay in RUN.
  - Else all enables are 1 and all bubbles/holds are 0.
- MEM_WAIT state:
  - Outputs are the same as the mem_stall case above.
  - Wait counter increments each cycle and saturates at MEM_TIMEOUT. On reaching MEM_TIMEOUT, mem_error is set to 1 and stays set until reset.
  - When mem_ready=1: outputs revert to the RUN values for this cycle, evaluated with branch_taken and load_use. Next state is RUN; wait counter clears.
- FLUSH state:
  - ifid_flush=1, idex_bubble=1, pc_write=1.
  - Counter decrements; at 1, next state is RUN.
  - A mem_stall during FLUSH takes priority: go to MEM_WAIT and discard the remaining flush count.
- Memory handshake: mem_req && mem_ready in the same cycle means zero wait and no state change.

Optional Feature:
- Macro: HAZARD_STALL_COUNTER_EN.
- Defined:
  - Adds output stall_count [CNT_W-1:0], reset to 0.
  - Increments every cycle in which pc_write=0 and reset is low.
  - Saturates at all-ones.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Load-use stall: ex_memread=1, ex_rd=5, id_rs=5, no other hazards → one cycle of pc_write=0, ifid_write=0, idex_bubble=1; the next cycle (ex_memread=0) has all enables at 1.
- Double forward: mem_regwrite=1, mem_rd=3, wb_regwrite=1, wb_rd=3, ex_rs=3, ex_rt=3 → fwd_a=fwd_b=10. Change mem_rd=0 → fwd_a=fwd_b=01. Change wb_rd=0 as well → fwd_a=fwd_b=00.
- Memory wait: mem_req=1, mem_ready=0 for 4 cycles, then 1 → state_o=1 for 4 cycles with exmem_hold=1 and memwb_bubble=1; RUN on the ready cycle; mem_error stays 0.
- Timeout: MEM_TIMEOUT=8, mem_ready held 0 → mem_error=1 after the 8th wait cycle. It stays 1 after mem_ready rises and clears only on reset.
- Branch plus load-use together: FLUSH_CYCLES=2, branch_taken=1 and load_use=1 in the same cycle → pc_write=1, ifid_flush=1 and idex_bubble=1 for 2 cycles; no load-use stall cycle.
- Asynchronous reset during MEM_WAIT (cycle 3): outputs take their reset values before the next edge; state_o=0; wait counter 0; with the macro defined, stall_count=0.
